mem_req_arbiter: RTL and testbench

- Shares the single word-level request port of the DRAM memory controller (32-bit addr/data, rw, valid, ready, busy) between NUM_REQ requesters, e.g. the core data port and the program loader.
- Runs on the CPU clock domain, in front of the cache/DDR2 controller.
- Grants round-robin and keeps exactly one transaction outstanding.
- Routes each response back to its owner; a watchdog reports a response that never arrives.

---
 rtl/mem_req_arbiter_pkg.sv | 20 ++
 rtl/mem_req_arbiter_if.sv | 44 ++++
 rtl/mem_req_arbiter_rr_arbiter.sv | 36 +++
 rtl/mem_req_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_req_arbiter.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and helpers for the DRAM request-port arbiter.
// Imported by the interface, the round-robin picker and the top.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Wide enough to hold TIMEOUT-1; a disabled watchdog still needs one bit.
    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester-side and controller-side signals of the arbiter.
// The arbiter uses the slave modport; the environment uses master.
interface mem_req_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import mem_arb_pkg::*;

    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_rw;
    logic [NUM_REQ-1:0][31:0] req_addr;
    logic [NUM_REQ-1:0][31:0] req_data;
    logic [NUM_REQ-1:0]       req_ack;
    logic [NUM_REQ-1:0]       res_valid;
    logic [31:0]              res_data;
    logic                     res_err;
    logic [31:0]              mem_req_addr;
    logic [31:0]              mem_req_data;
    logic                     mem_req_rw;
    logic                     mem_req_valid;
    logic [31:0]              mem_res_data;
    logic                     mem_res_ready;
    logic                     mem_busy;
    logic [IDW-1:0]           grant_id;
    logic                     idle;

    modport slave (
        input  req_valid, req_rw, req_addr, req_data,
        input  mem_res_data, mem_res_ready, mem_busy,
        output req_ack, res_valid, res_data, res_err,
        output mem_req_addr, mem_req_data, mem_req_rw, mem_req_valid,
        output grant_id, idle
    );

    modport master (
        output req_valid, req_rw, req_addr, req_data,
        output mem_res_data, mem_res_ready, mem_busy,
        input  req_ack, res_valid, res_data, res_err,
        input  mem_req_addr, mem_req_data, mem_req_rw, mem_req_valid,
        input  grant_id, idle
    );

endinterface

// File: rtl/mem_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above
// the pointer, wrapping modulo N.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] grant_o,
    output logic          any_o
);

    function automatic logic [IW-1:0] rot(input logic [IW-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    logic found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[rot(ptr_i, i)]) begin
                grant_o = rot(ptr_i, i);
                found   = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one DRAM request port between requesters,
// one transaction in flight, with a response watchdog.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int TIMEOUT = 4096,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input logic clk,
    input logic rstn,
    mem_req_arbiter_if.slave bus
);

    localparam int             CW    = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    state_t         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           rw_q, rw_d;
    logic           err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0] win;
    logic           any;
    logic           expired;
    logic [31:0]    rsp_data;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (win),
        .any_o   (any)
    );

    // Writes return no data even if the controller drives its bus.
    assign rsp_data = (rw_q == RW_READ) ? bus.mem_res_data : '0;
    assign expired  = (TIMEOUT != 0) && (cnt_q == LIMIT);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rw_d    = rw_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any && !bus.mem_busy) begin
                    grant_d = win;
                    addr_d  = bus.req_addr[win];
                    wdata_d = bus.req_data[win];
                    rw_d    = bus.req_rw[win] ? RW_WRITE : RW_READ;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                ptr_d = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                cnt_d = '0;
                if (bus.mem_res_ready) begin
                    rdata_d = rsp_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.mem_res_ready) begin
                    rdata_d = rsp_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rw_q    <= rw_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.mem_req_valid = (state_q == ISSUE);
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_data  = wdata_q;
    assign bus.mem_req_rw    = rw_q;
    assign bus.req_ack       = (state_q == ISSUE) ? (ONE << grant_q) : '0;
    assign bus.res_valid     = (state_q == RESP) ? (ONE << grant_q) : '0;
    assign bus.res_data      = rdata_q;
    assign bus.res_err       = (state_q == RESP) && err_q;
    assign bus.grant_id      = grant_q;
    assign bus.idle          = (state_q == IDLE);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scenario bench for mem_req_arbiter with a response scoreboard.
module tb_mem_req_arbiter;
    import mem_arb_pkg::*;

    localparam int NR = 2;
    localparam int TO = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    mem_req_arbiter_if #(.NUM_REQ(NR)) bus();

    mem_req_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [logic [31:0]];
    int          checks   = 0;
    int          failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid     = '0;
        bus.req_rw        = '0;
        bus.req_addr      = '0;
        bus.req_data      = '0;
        bus.mem_res_data  = '0;
        bus.mem_res_ready = 1'b0;
        bus.mem_busy      = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_inputs();
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    // Scoreboard: every completion must match the oldest expectation.
    always @(negedge clk) begin
        if (rstn && (bus.res_valid !== '0)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected res_valid=%b", bus.res_valid);
            end else begin
                exp_t e;
                logic [NR-1:0] oh;
                e = exp_q.pop_front();
                oh = '0;
                oh[e.id] = 1'b1;
                if (bus.res_valid !== oh || bus.res_data !== e.data ||
                    bus.res_err !== e.err) begin
                    failures++;
                    $display("FAIL sb_resp got v=%b d=%h e=%b exp v=%b d=%h e=%b",
                             bus.res_valid, bus.res_data, bus.res_err,
                             oh, e.data, e.err);
                end
            end
        end
    end

    task automatic test_reset();
        rstn = 1'b0;
        clear_inputs();
        tick();
        tick();
        checks++;
        if (bus.idle !== 1'b1) begin
            failures++;
            $display("FAIL rst_idle got=%b exp=1", bus.idle);
        end
        checks++;
        if ({bus.req_ack, bus.res_valid, bus.mem_req_valid, bus.res_err} !== '0) begin
            failures++;
            $display("FAIL rst_pulses got ack=%b rv=%b mv=%b err=%b exp all 0",
                     bus.req_ack, bus.res_valid, bus.mem_req_valid, bus.res_err);
        end
        checks++;
        if ({bus.mem_req_addr, bus.mem_req_data, bus.res_data} !== '0 ||
            bus.mem_req_rw !== 1'b0 || bus.grant_id !== '0) begin
            failures++;
            $display("FAIL rst_regs got a=%h d=%h rd=%h rw=%b g=%h exp 0",
                     bus.mem_req_addr, bus.mem_req_data, bus.res_data,
                     bus.mem_req_rw, bus.grant_id);
        end
        rstn = 1'b1;
        tick();
        checks++;
        if (bus.idle !== 1'b1 || bus.mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_release got idle=%b mv=%b exp 1/0",
                     bus.idle, bus.mem_req_valid);
        end
    endtask

    task automatic test_single_read();
        bus.req_valid   = 2'b01;
        bus.req_rw[0]   = RW_READ;
        bus.req_addr[0] = 32'h0000_0100;
        exp_q.push_back('{0, 32'hDEAD_BEEF, 1'b0});
        tick();
        checks++;
        if (bus.req_ack !== 2'b01 || bus.mem_req_valid !== 1'b1) begin
            failures++;
            $display("FAIL rd_issue got ack=%b mv=%b exp 01/1",
                     bus.req_ack, bus.mem_req_valid);
        end
        checks++;
        if (bus.mem_req_addr !== 32'h100 || bus.mem_req_rw !== 1'b0) begin
            failures++;
            $display("FAIL rd_fields got a=%h rw=%b exp 100/0",
                     bus.mem_req_addr, bus.mem_req_rw);
        end
        bus.req_valid = '0;
        tick();
        checks++;
        if (bus.mem_req_valid !== 1'b0 || bus.req_ack !== '0) begin
            failures++;
            $display("FAIL rd_pulse got mv=%b ack=%b exp 0/00",
                     bus.mem_req_valid, bus.req_ack);
        end
        tick();
        tick();
        tick();
        bus.mem_res_ready = 1'b1;
        bus.mem_res_data  = 32'hDEAD_BEEF;
        tick();
        bus.mem_res_ready = 1'b0;
        bus.mem_res_data  = 32'hFFFF_FFFF;
        checks++;
        if (bus.res_valid !== 2'b01 || bus.res_data !== 32'hDEAD_BEEF ||
            bus.res_err !== 1'b0) begin
            failures++;
            $display("FAIL rd_resp got v=%b d=%h e=%b exp 01/deadbeef/0",
                     bus.res_valid, bus.res_data, bus.res_err);
        end
        tick();
        checks++;
        if (bus.idle !== 1'b1 || bus.res_data !== 32'hDEAD_BEEF ||
            bus.mem_req_addr !== 32'h100) begin
            failures++;
            $display("FAIL rd_hold got idle=%b d=%h a=%h exp 1/deadbeef/100",
                     bus.idle, bus.res_data, bus.mem_req_addr);
        end
    endtask

    task automatic test_contention();
        int exp_g;
        int prev;
        logic [NR-1:0] oh;
        do_reset();
        exp_g = 0;
        prev  = -1;
        bus.req_valid   = 2'b11;
        bus.req_rw      = 2'b00;
        bus.req_addr[0] = 32'h200;
        bus.req_addr[1] = 32'h300;
        for (int k = 0; k < 4; k++) begin
            int n;
            n = 0;
            while (bus.mem_req_valid !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            oh = '0;
            oh[exp_g] = 1'b1;
            checks++;
            if (bus.mem_req_valid !== 1'b1) begin
                failures++;
                $display("FAIL cont_timeout txn=%0d no issue within 10 cycles", k);
            end
            checks++;
            if (bus.grant_id !== exp_g[0] || bus.req_ack !== oh ||
                int'(bus.grant_id) == prev) begin
                failures++;
                $display("FAIL cont_grant txn=%0d got g=%0d ack=%b exp g=%0d ack=%b",
                         k, bus.grant_id, bus.req_ack, exp_g, oh);
            end
            checks++;
            if (bus.mem_req_addr !== (exp_g == 1 ? 32'h300 : 32'h200)) begin
                failures++;
                $display("FAIL cont_addr txn=%0d got=%h", k, bus.mem_req_addr);
            end
            exp_q.push_back('{exp_g, 32'hA000_0000 + k, 1'b0});
            tick();
            tick();
            bus.mem_res_ready = 1'b1;
            bus.mem_res_data  = 32'hA000_0000 + k;
            tick();
            bus.mem_res_ready = 1'b0;
            if (k == 3) bus.req_valid = '0;
            checks++;
            if (bus.res_valid !== oh) begin
                failures++;
                $display("FAIL cont_owner txn=%0d got=%b exp=%b", k, bus.res_valid, oh);
            end
            prev  = exp_g;
            exp_g = 1 - exp_g;
        end
        tick();
        tick();
        checks++;
        if (bus.idle !== 1'b1 || bus.mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL cont_drain got idle=%b mv=%b exp 1/0",
                     bus.idle, bus.mem_req_valid);
        end
    endtask

    task automatic test_busy_gating();
        int bad;
        bad = 0;
        bus.mem_busy    = 1'b1;
        bus.req_valid   = 2'b10;
        bus.req_rw[1]   = RW_READ;
        bus.req_addr[1] = 32'h500;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.mem_req_valid !== 1'b0 || bus.req_ack !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL busy_block got %0d issuing cycles exp 0", bad);
        end
        bus.mem_busy = 1'b0;
        exp_q.push_back('{1, 32'h55AA_55AA, 1'b0});
        tick();
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.req_ack !== 2'b10) begin
            failures++;
            $display("FAIL busy_release got mv=%b ack=%b exp 1/10",
                     bus.mem_req_valid, bus.req_ack);
        end
        bus.req_valid     = '0;
        bus.mem_busy      = 1'b1;
        bus.mem_res_ready = 1'b1;
        bus.mem_res_data  = 32'h55AA_55AA;
        tick();
        bus.mem_res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 2'b10 || bus.res_data !== 32'h55AA_55AA) begin
            failures++;
            $display("FAIL busy_fast_resp got v=%b d=%h exp 10/55aa55aa",
                     bus.res_valid, bus.res_data);
        end
        bus.mem_busy = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        int early;
        early = 0;
        bus.req_valid    = 2'b01;
        bus.req_rw[0]    = RW_READ;
        bus.req_addr[0]  = 32'h80;
        bus.mem_res_data = 32'hFFFF_FFFF;
        exp_q.push_back('{0, 32'h0, 1'b1});
        tick();
        bus.req_valid = '0;
        for (int i = 0; i < TO; i++) begin
            tick();
            if (bus.res_valid !== '0) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL wd_early got %0d early responses exp 0", early);
        end
        tick();
        checks++;
        if (bus.res_valid !== 2'b01 || bus.res_err !== 1'b1 || bus.res_data !== 32'h0) begin
            failures++;
            $display("FAIL wd_expire got v=%b e=%b d=%h exp 01/1/0",
                     bus.res_valid, bus.res_err, bus.res_data);
        end
        tick();
        bus.req_valid   = 2'b10;
        bus.req_addr[1] = 32'h84;
        exp_q.push_back('{1, 32'h1357_2468, 1'b0});
        tick();
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.req_ack !== 2'b10) begin
            failures++;
            $display("FAIL wd_next_issue got mv=%b ack=%b exp 1/10",
                     bus.mem_req_valid, bus.req_ack);
        end
        bus.req_valid = '0;
        for (int i = 0; i < TO; i++) tick();
        bus.mem_res_ready = 1'b1;
        bus.mem_res_data  = 32'h1357_2468;
        tick();
        bus.mem_res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 2'b10 || bus.res_err !== 1'b0 ||
            bus.res_data !== 32'h1357_2468) begin
            failures++;
            $display("FAIL wd_tie got v=%b e=%b d=%h exp 10/0/13572468",
                     bus.res_valid, bus.res_err, bus.res_data);
        end
        tick();
    endtask

    task automatic test_write_then_read();
        bus.req_valid   = 2'b10;
        bus.req_rw[1]   = RW_WRITE;
        bus.req_addr[1] = 32'h40;
        bus.req_data[1] = 32'hCAFE_BABE;
        model_mem[32'h40] = 32'hCAFE_BABE;
        exp_q.push_back('{1, 32'h0, 1'b0});
        tick();
        checks++;
        if (bus.mem_req_rw !== 1'b1 || bus.mem_req_addr !== 32'h40 ||
            bus.mem_req_data !== 32'hCAFE_BABE) begin
            failures++;
            $display("FAIL wr_issue got rw=%b a=%h d=%h exp 1/40/cafebabe",
                     bus.mem_req_rw, bus.mem_req_addr, bus.mem_req_data);
        end
        bus.req_valid = '0;
        tick();
        bus.mem_res_ready = 1'b1;
        bus.mem_res_data  = 32'h1234_5678;
        tick();
        bus.mem_res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 2'b10 || bus.res_data !== 32'h0) begin
            failures++;
            $display("FAIL wr_resp got v=%b d=%h exp 10/0", bus.res_valid, bus.res_data);
        end
        tick();
        checks++;
        if (bus.mem_req_rw !== 1'b1 || bus.mem_req_data !== 32'hCAFE_BABE) begin
            failures++;
            $display("FAIL wr_hold got rw=%b d=%h exp 1/cafebabe",
                     bus.mem_req_rw, bus.mem_req_data);
        end
        bus.req_valid   = 2'b01;
        bus.req_rw[0]   = RW_READ;
        bus.req_addr[0] = 32'h40;
        exp_q.push_back('{0, model_mem[32'h40], 1'b0});
        tick();
        checks++;
        if (bus.mem_req_rw !== 1'b0 || bus.req_ack !== 2'b01) begin
            failures++;
            $display("FAIL rd40_issue got rw=%b ack=%b exp 0/01",
                     bus.mem_req_rw, bus.req_ack);
        end
        bus.req_valid = '0;
        tick();
        bus.mem_res_ready = 1'b1;
        bus.mem_res_data  = model_mem[32'h40];
        tick();
        bus.mem_res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 2'b01 || bus.res_data !== 32'hCAFE_BABE) begin
            failures++;
            $display("FAIL rd40_resp got v=%b d=%h exp 01/cafebabe",
                     bus.res_valid, bus.res_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        int stray;
        stray = 0;
        bus.req_valid   = 2'b10;
        bus.req_rw[1]   = RW_READ;
        bus.req_addr[1] = 32'h300;
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        checks++;
        if (bus.idle !== 1'b0) begin
            failures++;
            $display("FAIL rmw_inwait got idle=%b exp 0", bus.idle);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.idle !== 1'b1 || bus.grant_id !== '0 || bus.mem_req_addr !== '0 ||
            bus.res_data !== '0 || bus.mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL rmw_async got idle=%b g=%h a=%h d=%h mv=%b exp 1/0/0/0/0",
                     bus.idle, bus.grant_id, bus.mem_req_addr, bus.res_data,
                     bus.mem_req_valid);
        end
        tick();
        rstn = 1'b1;
        bus.mem_res_ready = 1'b1;
        bus.mem_res_data  = 32'hBEEF_0000;
        tick();
        bus.mem_res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (bus.res_valid !== '0) stray++;
            tick();
        end
        checks++;
        if (stray != 0 || bus.idle !== 1'b1) begin
            failures++;
            $display("FAIL rmw_late got stray=%0d idle=%b exp 0/1", stray, bus.idle);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_busy_gating();
        test_watchdog();
        test_write_then_read();
        test_reset_mid_wait();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got %0d pending exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
